// File: rtl/hazard_stall_unit_if.sv
// rtl/hazard_stall_unit_if.sv - hazard/stall control bundle between pipeline and hazard unit
//
// Groups the hazard-detection inputs and the pipeline hold/clear controls.
//   master : pipeline side, drives hazard terms, receives stall/flush controls
//   slave  : hazard unit side
interface hazard_stall_unit_if;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic        rs1_used_id;
    logic        rs2_used_id;
    logic [4:0]  rd_exe;
    logic        MemRead_exe;
    logic        RegWen_exe;
    logic        branch_taken_exe;
    logic        div_start_exe;
    logic        div_done;
    logic        mem_req_mem;
    logic        mem_ready;
    logic        stall_pc;
    logic        stall_if_id;
    logic        stall_id_exe;
    logic        stall_exe_mem;
    logic        flush_if_id;
    logic        flush_id_exe;
    logic        flush_exe_mem;
    logic        flush_mem_wb;
    logic        mem_error;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    modport master (
        output rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_exe,
               MemRead_exe, RegWen_exe, branch_taken_exe,
               div_start_exe, div_done, mem_req_mem, mem_ready,
        input  stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
               flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb,
               mem_error, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_exe,
               MemRead_exe, RegWen_exe, branch_taken_exe,
               div_start_exe, div_done, mem_req_mem, mem_ready,
        output stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
               flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb,
               mem_error, stall_cycles, flush_count
    );
endinterface

// File: rtl/hazard_stall_unit.sv
// rtl/hazard_stall_unit.sv - stall/flush controller for load-use, branch, memory and divider hazards
//
// Ports:
//   clk   : pipeline clock
//   rst_n : asynchronous active-low reset; forces all stall/flush controls low
//   hz    : hazard_stall_unit_if.slave - hazard inputs, stall/flush controls,
//           sticky mem_error, stall_cycles and flush_count counters
module hazard_stall_unit #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_stall_unit_if.slave hz
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, DIV_WAIT} state_t;

    state_t      state, state_next;
    logic [15:0] timer, timer_next;
    logic        err_set;
    logic        branch_sel;
    logic [7:0]  ctl;
    logic        mem_error_q;
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_count_q;

    logic        load_use;
    logic        mem_freeze;
    logic        div_freeze;
    logic        timeout;
    logic [16:0] timer_inc;

    assign load_use = hz.MemRead_exe & hz.RegWen_exe & (hz.rd_exe != 5'd0) &
                      ((hz.rs1_used_id & (hz.rs1_id == hz.rd_exe)) |
                       (hz.rs2_used_id & (hz.rs2_id == hz.rd_exe)));

    assign mem_freeze = hz.mem_req_mem & ~hz.mem_ready &
                        ((state == RUN) | (state == MEM_WAIT));

    assign div_freeze = ~mem_freeze & hz.div_start_exe & ~hz.div_done &
                        ((state == RUN) | (state == DIV_WAIT));

    // Timeout fires in the MEM_WAIT cycle whose increment would bring the
    // timer to MEM_TIMEOUT; a same-cycle mem_ready takes precedence.
    assign timer_inc = {1'b0, timer} + 17'd1;
    assign timeout   = (state == MEM_WAIT) & ~hz.mem_ready &
                       ({15'd0, timer_inc} >= MEM_TIMEOUT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= RUN;
            timer          <= 16'd0;
            mem_error_q    <= 1'b0;
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            state          <= state_next;
            timer          <= timer_next;
            mem_error_q    <= mem_error_q | err_set;
            stall_cycles_q <= stall_cycles_q + {31'd0, ctl[7]};
            flush_count_q  <= flush_count_q + {31'd0, branch_sel};
        end
    end

    // ctl = {stall_pc, stall_if_id, stall_id_exe, stall_exe_mem,
    //        flush_if_id, flush_id_exe, flush_exe_mem, flush_mem_wb}
    always_comb begin
        state_next = state;
        timer_next = timer;
        err_set    = 1'b0;
        branch_sel = 1'b0;
        ctl        = 8'b0000_0000;

        if (mem_freeze) begin
            ctl = 8'b1111_0001;
        end else if (div_freeze) begin
            ctl = 8'b1110_0010;
        end else if (hz.branch_taken_exe) begin
            ctl        = 8'b0000_1100;
            branch_sel = 1'b1;
        end else if (load_use) begin
            ctl = 8'b1100_0100;
        end

        // Aborted access must not reach write-back even if the request dropped.
        if (timeout) begin
            ctl[0] = 1'b1;
        end

        case (state)
            RUN: begin
                if (hz.mem_req_mem & ~hz.mem_ready) begin
                    state_next = MEM_WAIT;
                    timer_next = 16'd0;
                end else if (hz.div_start_exe & ~hz.div_done) begin
                    state_next = DIV_WAIT;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_next = RUN;
                end else if (timeout) begin
                    state_next = RUN;
                    err_set    = 1'b1;
                end else begin
                    timer_next = timer_inc[15:0];
                end
            end
            DIV_WAIT: begin
                if (hz.div_done) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase

        if (!rst_n) begin
            ctl        = 8'b0000_0000;
            branch_sel = 1'b0;
        end
    end

    assign hz.stall_pc      = ctl[7];
    assign hz.stall_if_id   = ctl[6];
    assign hz.stall_id_exe  = ctl[5];
    assign hz.stall_exe_mem = ctl[4];
    assign hz.flush_if_id   = ctl[3];
    assign hz.flush_id_exe  = ctl[2];
    assign hz.flush_exe_mem = ctl[1];
    assign hz.flush_mem_wb  = ctl[0];
    assign hz.mem_error     = mem_error_q;
    assign hz.stall_cycles  = stall_cycles_q;
    assign hz.flush_count   = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb/tb_hazard_stall_unit.sv - self-checking bench for hazard_stall_unit
module tb_hazard_stall_unit;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_unit_if hz();

    hazard_stall_unit #(.MEM_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference: mode 0 = running, 1 = waiting on memory, 2 = waiting on divider
    int          m_mode  = 0;
    int          m_wait  = 0;
    logic        m_err   = 1'b0;
    logic [31:0] m_stall = 32'd0;
    logic [31:0] m_flush = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] observed_ctl();
        return {hz.stall_pc, hz.stall_if_id, hz.stall_id_exe, hz.stall_exe_mem,
                hz.flush_if_id, hz.flush_id_exe, hz.flush_exe_mem, hz.flush_mem_wb};
    endfunction

    function automatic bit model_timeout();
        return (m_mode == 1) && !hz.mem_ready && (m_wait + 1 >= TO);
    endfunction

    // Priority table applied directly to the current inputs and reference mode.
    function automatic logic [7:0] model_ctl(output bit is_branch);
        bit lu, mf, df;
        logic [7:0] r;
        lu = hz.MemRead_exe && hz.RegWen_exe && hz.rd_exe != 0 &&
             ((hz.rs1_used_id && hz.rs1_id == hz.rd_exe) ||
              (hz.rs2_used_id && hz.rs2_id == hz.rd_exe));
        mf = hz.mem_req_mem && !hz.mem_ready && m_mode != 2;
        df = !mf && hz.div_start_exe && !hz.div_done && m_mode != 1;
        is_branch = 0;
        if (mf)                         r = 8'b1111_0001;
        else if (df)                    r = 8'b1110_0010;
        else if (hz.branch_taken_exe) begin
            r = 8'b0000_1100;
            is_branch = 1;
        end
        else if (lu)                    r = 8'b1100_0100;
        else                            r = 8'b0000_0000;
        if (model_timeout()) r[0] = 1'b1;
        return r;
    endfunction

    task automatic idle();
        hz.rs1_id = 0; hz.rs2_id = 0; hz.rs1_used_id = 0; hz.rs2_used_id = 0;
        hz.rd_exe = 0; hz.MemRead_exe = 0; hz.RegWen_exe = 0;
        hz.branch_taken_exe = 0; hz.div_start_exe = 0; hz.div_done = 0;
        hz.mem_req_mem = 0; hz.mem_ready = 0;
    endtask

    // Called just after a falling edge with inputs applied: checks, then advances one clock.
    task automatic cycle(input string tag);
        logic [7:0] e;
        bit br, to;
        #2;
        e  = model_ctl(br);
        to = model_timeout();
        chk({tag, "/ctl"}, {24'd0, observed_ctl()}, {24'd0, e});
        chk({tag, "/err"}, {31'd0, hz.mem_error}, {31'd0, m_err});
        chk({tag, "/stall_cycles"}, hz.stall_cycles, m_stall);
        chk({tag, "/flush_count"}, hz.flush_count, m_flush);
        @(posedge clk);
        m_stall = m_stall + {31'd0, e[7]};
        m_flush = m_flush + {31'd0, br};
        case (m_mode)
            0: if (hz.mem_req_mem && !hz.mem_ready) begin m_mode = 1; m_wait = 0; end
               else if (hz.div_start_exe && !hz.div_done) m_mode = 2;
            1: if (hz.mem_ready) m_mode = 0;
               else if (to) begin m_mode = 0; m_err = 1'b1; end
               else m_wait++;
            default: if (hz.div_done) m_mode = 0;
        endcase
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        hz.mem_req_mem = 1; hz.branch_taken_exe = 1; hz.div_start_exe = 1;
        rst_n = 1'b0;
        #1;
        chk({tag, "/ctl"}, {24'd0, observed_ctl()}, 32'd0);
        chk({tag, "/err"}, {31'd0, hz.mem_error}, 32'd0);
        chk({tag, "/stall_cycles"}, hz.stall_cycles, 32'd0);
        chk({tag, "/flush_count"}, hz.flush_count, 32'd0);
        m_mode = 0; m_wait = 0; m_err = 0; m_stall = 0; m_flush = 0;
        @(negedge clk);
        idle();
        rst_n = 1'b1;
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset("reset0");

        // load-use on rs1
        hz.MemRead_exe = 1; hz.RegWen_exe = 1; hz.rd_exe = 5; hz.rs1_id = 5; hz.rs1_used_id = 1;
        cycle("lu");
        idle();
        cycle("lu_next");
        chk("lu_stall_total", hz.stall_cycles, 32'd1);

        // x0 load and unused rs2 never stall
        hz.MemRead_exe = 1; hz.RegWen_exe = 1; hz.rd_exe = 0; hz.rs1_id = 0; hz.rs1_used_id = 1;
        cycle("lu_x0");
        hz.rd_exe = 5; hz.rs1_id = 3; hz.rs2_id = 5; hz.rs2_used_id = 0;
        cycle("lu_rs2_unused");

        // taken branch overrides load-use
        hz.rs1_id = 5; hz.branch_taken_exe = 1;
        cycle("br_lu");
        idle();
        cycle("br_after");
        chk("br_flush_total", hz.flush_count, 32'd1);

        // memory wait: ready 3 cycles after request
        hz.mem_req_mem = 1;
        repeat (3) cycle("memwait");
        hz.mem_ready = 1;
        cycle("mem_ready");
        idle();
        cycle("mem_after");
        chk("mem_stall_total", hz.stall_cycles, 32'd4);

        // timeout: ready never arrives
        hz.mem_req_mem = 1;
        repeat (5) cycle("timeout");
        idle();
        cycle("timeout_after");
        chk("timeout_err", {31'd0, hz.mem_error}, 32'd1);

        // reset in the middle of MEM_WAIT
        hz.mem_req_mem = 1;
        repeat (2) cycle("pre_reset");
        do_reset("reset_mid");
        cycle("post_reset");

        // load waits 2 cycles in MEM while a divide sits in EXE
        hz.mem_req_mem = 1; hz.div_start_exe = 1;
        repeat (2) cycle("ld_div_mem");
        hz.mem_ready = 1;
        cycle("ld_div_ready");
        hz.mem_req_mem = 0; hz.mem_ready = 0;
        repeat (3) cycle("ld_div_div");
        hz.div_done = 1;
        cycle("ld_div_done");
        idle();
        cycle("ld_div_after");

        // randomized traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            hz.rs1_id           = 5'($urandom_range(0, 3));
            hz.rs2_id           = 5'($urandom_range(0, 3));
            hz.rd_exe           = 5'($urandom_range(0, 3));
            hz.rs1_used_id      = 1'($urandom_range(0, 1));
            hz.rs2_used_id      = 1'($urandom_range(0, 1));
            hz.MemRead_exe      = 1'($urandom_range(0, 1));
            hz.RegWen_exe       = ($urandom_range(0, 3) != 0);
            hz.branch_taken_exe = ($urandom_range(0, 5) == 0);
            hz.div_start_exe    = ($urandom_range(0, 4) == 0);
            hz.div_done         = ($urandom_range(0, 3) == 0);
            hz.mem_req_mem      = ($urandom_range(0, 3) == 0);
            hz.mem_ready        = ($urandom_range(0, 9) < 4);
            if (i % 997 == 500) do_reset("rand_reset");
            else cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
